sa_cache_ctrl: RTL
==================

Name: sa_cache_ctrl

Overview:
- Parametrised set-associative write-back, write-allocate L1 data cache controller with internal tag/data/LRU arrays.
- Sits between the MEM stage (CPU port), the store buffer (drain port) and the line-granular memory controller.
- Generalises the direct-mapped controller to WAYS ways with LRU replacement.
- Drain misses are allocated correctly (fill, then write) instead of blindly overwriting the indexed line.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, CPU word width; power of two, at least 8.
- LINE_WORDS, 4, words per line; power of two.
- SETS, 4, number of sets; power of two.
- WAYS, 2, associativity: 1, 2, 4 or 8.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- cpu_valid  in  1  CPU request present; held until cpu_ready.
- cpu_rw  in  1  0 = load, 1 = store (tag/dirty only; data comes later via drain).
- cpu_addr  in  ADDR_W  byte address.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  load word, valid while cpu_ready=1.
- sb_drain_valid  in  1  store buffer head valid.
- sb_drain_addr  in  ADDR_W  drain address.
- sb_drain_data  in  DATA_W  drain word.
- sb_drain_done  out  1  one-cycle pulse: head word written into the cache.
- force_drain  in  1  drain has priority over the CPU.
- mem_req_valid  out  1  memory request; held until mem_resp_ready.
- mem_req_rw  out  1  0 = line read, 1 = line write-back.
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero).
- mem_req_data  out  LINE_WORDS*DATA_W  victim line for write-back.
- mem_resp_ready  in  1  current request completed.
- mem_resp_data  in  LINE_WORDS*DATA_W  fill data on a read completion.

Behaviour:
- Address split: OFF = log2(LINE_WORDS*DATA_W/8); index = addr[OFF+log2(SETS)-1:OFF]; tag = the remaining upper bits.
- Arrays are registers with combinational read.
- Reset (reset_n=0 at a clock edge): state=IDLE; all valid/dirty cleared; LRU age of way w = w. All outputs 0 in the following cycle. Reset mid-transaction aborts it: mem_req_valid drops, and no partial fill is kept.
- Arbitration in IDLE: sb_drain_valid && force_drain -> drain; else cpu_valid -> CPU; else sb_drain_valid -> drain. The winner's owner, addr and data are latched and used until completion. Inputs are not re-arbitrated mid-transaction.
- States:
  - IDLE -> COMPARE when a request is accepted.
  - COMPARE, hit:
    - CPU: cpu_ready=1 and cpu_rdata = addressed word. A store sets the dirty bit.
    - Drain: write the word, set dirty, sb_drain_done=1.
    - Either way: update LRU, -> IDLE.
    - Load-hit latency = 2 cycles from acceptance.
  - COMPARE, miss: choose victim = lowest-index invalid way, else the way with the maximum age.
    - Victim valid and dirty: mem_req_valid=1, rw=1, addr = {victim tag, index, 0}, data = victim line, -> WRITE_BACK.
    - Otherwise: mem_req_valid=1, rw=0, addr = line address, -> ALLOCATE.
  - WRITE_BACK: hold the request. On mem_resp_ready, issue the read in the same cycle (rw=0, line address), -> ALLOCATE.
  - ALLOCATE: hold the read. On mem_resp_ready: write mem_resp_data into the victim way, valid=1, dirty=0, tag = request tag, -> COMPARE (the re-compare hits).
- LRU update on hit/fill: the accessed way's age becomes 0; every way with a smaller age increments by 1. Ages stay a permutation of 0..WAYS-1.
- mem_req_* are stable while mem_req_valid=1. mem_resp_ready is ignored outside WRITE_BACK/ALLOCATE.
- Each of cpu_ready and sb_drain_done pulses exactly once per accepted request, never both in one cycle.
- WAYS=1 degenerates to direct-mapped; the victim is always way 0.

Test Plan (SETS=4, WAYS=2, LINE_WORDS=4; index = addr[5:4]):
1. After reset, load 0x104 -> mem read at 0x100. Respond with words {0x11,0x22,0x33,0x44} -> cpu_ready, cpu_rdata=0x22. A repeat load of 0x104 gives cpu_ready exactly 2 cycles after acceptance with no mem_req.
2. Load 0x100, then 0x140, then 0x100 again; then load 0x180 -> the victim is 0x140 (mem read 0x180, no write-back); a following load of 0x100 hits.
3. Load 0x100; drain 0x100/0xDEADBEEF (hit, done in 2 cycles); load 0x140, then 0x180 -> write-back at addr 0x100 with word0=0xDEADBEEF, then read at 0x180.
4. cpu_valid=1 and sb_drain_valid=1 in IDLE: with force_drain=1, drain is served first and cpu_ready stays 0 until the drain is done; with force_drain=0, the CPU is served first.
5. Drain to 0x240 with no valid lines -> mem read at 0x240, fill, then a single sb_drain_done. The line is dirty and holds the data at word 0.
6. reset_n=0 while in ALLOCATE -> mem_req_valid=0 next cycle. A subsequent load of the same address misses again.

Source files
------------

// File: rtl/sa_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_cache_ctrl
// Brief    : Set-associative write-back/write-allocate L1 D-cache controller
//            with LRU replacement, CPU port, store-buffer drain port and a
//            line-granular memory port.
// Revision : 1.0 - initial release
// ============================================================================
module sa_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 4,
    parameter int WAYS       = 2
) (
    input  logic                         clock_i,
    input  logic                         reset_n_i,
    input  logic                         cpu_valid_i,
    input  logic                         cpu_rw_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    output logic                         cpu_ready_o,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    input  logic                         sb_drain_valid_i,
    input  logic [ADDR_W-1:0]            sb_drain_addr_i,
    input  logic [DATA_W-1:0]            sb_drain_data_i,
    output logic                         sb_drain_done_o,
    input  logic                         force_drain_i,
    output logic                         mem_req_valid_o,
    output logic                         mem_req_rw_o,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [LINE_WORDS*DATA_W-1:0] mem_req_data_o,
    input  logic                         mem_resp_ready_i,
    input  logic [LINE_WORDS*DATA_W-1:0] mem_resp_data_i
);
    localparam int LINE_W   = LINE_WORDS * DATA_W;
    localparam int OFF      = $clog2(LINE_W / 8);
    localparam int WOFF     = $clog2(DATA_W / 8);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int IDX_W    = (SETS > 1) ? IDX_BITS : 1;
    localparam int WSEL_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W    = ADDR_W - OFF - IDX_BITS;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                drain_q, drain_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAY_W-1:0]    victim_q, victim_d;

    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]   line_q  [SETS][WAYS];
    logic [WAY_W-1:0]    age_q   [SETS][WAYS];

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   req_word;
    logic [ADDR_W-1:0]   req_line_addr;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    victim;
    logic [WAY_W-1:0]    sel_way;
    logic [WAY_W-1:0]    acc_way;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   hit_line;
    logic                do_hit;
    logic                do_fill;

    assign req_idx       = IDX_W'((addr_q >> OFF) & ADDR_W'(SETS - 1));
    assign req_tag       = TAG_W'(addr_q >> (OFF + IDX_BITS));
    assign req_word      = WSEL_W'((addr_q >> WOFF) & ADDR_W'(LINE_WORDS - 1));
    assign req_line_addr = addr_q & ~ADDR_W'((64'd1 << OFF) - 64'd1);
    assign hit_line      = line_q[req_idx][hit_way];
    assign sel_way       = (state_q == S_COMPARE) ? victim : victim_q;
    assign sel_addr      = (ADDR_W'(tag_q[req_idx][sel_way]) << (OFF + IDX_BITS))
                         | (ADDR_W'(req_idx) << OFF);
    assign acc_way       = do_fill ? victim_q : hit_way;

    // Lowest-index match/invalid way wins, hence the descending loops.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        victim    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        victim_d        = victim_q;
        cpu_ready_o     = 1'b0;
        cpu_rdata_o     = '0;
        sb_drain_done_o = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_rw_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        do_hit          = 1'b0;
        do_fill         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sb_drain_valid_i && (force_drain_i || !cpu_valid_i)) begin
                    drain_d = 1'b1;
                    rw_d    = 1'b1;
                    addr_d  = sb_drain_addr_i;
                    wdata_d = sb_drain_data_i;
                    state_d = S_COMPARE;
                end else if (cpu_valid_i) begin
                    drain_d = 1'b0;
                    rw_d    = cpu_rw_i;
                    addr_d  = cpu_addr_i;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    do_hit = 1'b1;
                    if (drain_q) begin
                        sb_drain_done_o = 1'b1;
                    end else begin
                        cpu_ready_o = 1'b1;
                        cpu_rdata_o = hit_line[req_word*DATA_W +: DATA_W];
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_d        = victim;
                    mem_req_valid_o = 1'b1;
                    if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                        mem_req_rw_o   = 1'b1;
                        mem_req_addr_o = sel_addr;
                        mem_req_data_o = line_q[req_idx][victim];
                        state_d        = S_WRITE_BACK;
                    end else begin
                        mem_req_addr_o = req_line_addr;
                        state_d        = S_ALLOCATE;
                    end
                end
            end
            S_WRITE_BACK: begin
                mem_req_valid_o = 1'b1;
                if (mem_resp_ready_i) begin
                    mem_req_addr_o = req_line_addr;
                    state_d        = S_ALLOCATE;
                end else begin
                    mem_req_rw_o   = 1'b1;
                    mem_req_addr_o = sel_addr;
                    mem_req_data_o = line_q[req_idx][victim_q];
                end
            end
            S_ALLOCATE: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = req_line_addr;
                if (mem_resp_ready_i) begin
                    do_fill = 1'b1;
                    state_d = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            drain_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
        end
    end

    // Accessed way becomes youngest; only younger ways age, so ages stay a permutation.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    line_q[s][w]  <= '0;
                    age_q[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (do_hit || do_fill) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == acc_way) begin
                        age_q[req_idx][w] <= '0;
                    end else if (age_q[req_idx][w] < age_q[req_idx][acc_way]) begin
                        age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
                    end
                end
            end
            if (do_fill) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                tag_q[req_idx][victim_q]   <= req_tag;
                line_q[req_idx][victim_q]  <= mem_resp_data_i;
            end
            if (do_hit && (drain_q || rw_q)) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (do_hit && drain_q) begin
                line_q[req_idx][hit_way][req_word*DATA_W +: DATA_W] <= wdata_q;
            end
        end
    end
endmodule
`default_nettype wire
